// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the dmem_bank data memory.
// Optional per-byte parity storage is enabled with DMEM_PARITY_EN.
package dmem_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Ceil-log2 that never returns zero, so derived fields always have a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    function automatic int unsigned off_width(input int unsigned data_w);
        return clog2_min1(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// Request/response channel of dmem_bank; rsp_perr exists only with DMEM_PARITY_EN.
interface dmem_bank_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BYTES-1:0]  req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;
`ifdef DMEM_PARITY_EN
    logic              rsp_perr;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
`ifdef DMEM_PARITY_EN
        , input rsp_perr
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
`ifdef DMEM_PARITY_EN
        , output rsp_perr
`endif
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Word-indexed storage array with per-lane write enables; read is combinational.
// Lane width is 8, or 9 when the parent stores parity (DMEM_PARITY_EN).
module dmem_byte_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned BYTES  = 2,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [BYTES-1:0][LANE_W-1:0]  wr_data,
    input  logic [BYTES-1:0]              wr_be,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [BYTES-1:0][LANE_W-1:0]  rd_data
);

    logic [BYTES-1:0][LANE_W-1:0] mem [DEPTH];

    // Contents are cleared by the parent's zero-sweep, so the array has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < int'(BYTES); k++) begin
                if (wr_be[k]) begin
                    mem[wr_idx][k] <= wr_data[k];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_bank.sv
// Byte-enabled data memory with valid/ready requests, one-cycle registered
// response, range/alignment errors and a zero-sweep after reset.
// Define DMEM_PARITY_EN to add per-byte even parity and the rsp_perr output.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_bank_if.slave   bus
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = off_width(DATA_W);
    localparam int unsigned IDX_W = idx_width(DEPTH);
`ifdef DMEM_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              err;
`ifdef DMEM_PARITY_EN
        logic              perr;
`endif
    } rsp_t;

    dmem_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             cnt_q, cnt_d;
    logic                         ready_q, ready_d;
    logic                         done_q, done_d;
    rsp_t                         rsp_q, rsp_d;

    logic                         wr_en;
    logic [IDX_W-1:0]             wr_idx;
    logic [BYTES-1:0][LANE_W-1:0] wr_lanes;
    logic [BYTES-1:0]             wr_be;
    logic [BYTES-1:0][LANE_W-1:0] rd_lanes;
    logic [BYTES-1:0][LANE_W-1:0] store_lanes;
    logic [DATA_W-1:0]            rd_word;
`ifdef DMEM_PARITY_EN
    logic                         rd_perr;
`endif

    logic [IDX_W-1:0]             req_idx;
    logic                         off_bad;
    logic                         idx_bad;
    logic                         hi_bad;
    logic                         req_err;

    // Address decode and error classification.
    assign req_idx = bus.req_addr[OFF_W +: IDX_W];
    assign off_bad = |bus.req_addr[OFF_W-1:0];
    assign idx_bad = {1'b0, req_idx} >= (IDX_W+1)'(DEPTH);
    assign hi_bad  = |(bus.req_addr >> (OFF_W + IDX_W));
    assign req_err = off_bad | idx_bad | hi_bad;

    dmem_byte_ram #(
        .DEPTH  (DEPTH),
        .BYTES  (BYTES),
        .LANE_W (LANE_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_lanes),
        .wr_be   (wr_be),
        .rd_idx  (req_idx),
        .rd_data (rd_lanes)
    );

    // Lane packing for stores and unpacking / parity check for loads.
    always_comb begin
        store_lanes = '0;
        rd_word     = '0;
`ifdef DMEM_PARITY_EN
        rd_perr     = 1'b0;
`endif
        for (int k = 0; k < int'(BYTES); k++) begin
`ifdef DMEM_PARITY_EN
            store_lanes[k] = {^bus.req_wdata[8*k +: 8], bus.req_wdata[8*k +: 8]};
            rd_perr        = rd_perr | (^rd_lanes[k]);
`else
            store_lanes[k] = bus.req_wdata[8*k +: 8];
`endif
            rd_word[8*k +: 8] = rd_lanes[k][7:0];
        end
    end

    // Next-state, write-port and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        done_d   = done_q;
        rsp_d    = '0;
        wr_en    = 1'b0;
        wr_idx   = cnt_q;
        wr_lanes = '0;
        wr_be    = '0;

        case (state_q)
            INIT: begin
                wr_en = 1'b1;
                wr_be = '1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (bus.req_valid && ready_q) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.err   = req_err;
                    if (!req_err) begin
                        if (bus.req_write) begin
                            wr_en    = 1'b1;
                            wr_idx   = req_idx;
                            wr_lanes = store_lanes;
                            wr_be    = bus.req_be;
                        end else begin
                            rsp_d.rdata = rd_word;
`ifdef DMEM_PARITY_EN
                            rsp_d.perr  = rd_perr;
`endif
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.init_done = done_q;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;
`ifdef DMEM_PARITY_EN
    assign bus.rsp_perr  = rsp_q.perr;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: vector table plus reset/sweep and pipelining sequences.
// Parity checks are compiled in only with DMEM_PARITY_EN.
module tb_dmem_bank;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NVEC   = 15;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    dmem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [15:0] rd, input logic err);
        chk({name, ".valid"}, 32'(bus.rsp_valid), 32'(v));
        chk({name, ".rdata"}, 32'(bus.rsp_rdata), 32'(rd));
        chk({name, ".err"},   32'(bus.rsp_err),   32'(err));
    endtask

    task automatic load(input string name, input logic [15:0] a, input logic [15:0] exp);
        drive(1'b1, 1'b0, a, 16'h0, 2'b00);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        chk_rsp(name, 1'b1, exp, 1'b0);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        drive(1'b1, 1'b1, a, d, be);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic wait_init(input string name);
        int cycles;
        bit ready_early;
        cycles = 0;
        ready_early = 1'b0;
        while (bus.init_done !== 1'b1 && cycles < 400) begin
            step();
            cycles++;
            if (bus.init_done !== 1'b1 && bus.req_ready !== 1'b0) ready_early = 1'b1;
        end
        chk({name, ".init_cycles"}, 32'(cycles), 32'(DEPTH));
        chk({name, ".ready_low"},   32'(ready_early), 32'd0);
        chk({name, ".ready_high"},  32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{1'b0, 16'h00FE, 16'h0000, 2'b00, 16'h0000, 1'b0},
            '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0},
            '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0},
            '{1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000, 1'b0},
            '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0},
            '{1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000, 1'b0},
            '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0},
            '{1'b0, 16'h0011, 16'h0000, 2'b00, 16'h0000, 1'b1},
            '{1'b1, 16'h0200, 16'h5555, 2'b11, 16'h0000, 1'b1},
            '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0},
            '{1'b1, 16'h0002, 16'hC3A7, 2'b10, 16'h0000, 1'b0},
            '{1'b0, 16'h0002, 16'h0000, 2'b00, 16'hC300, 1'b0},
            '{1'b0, 16'hFFFE, 16'h0000, 2'b00, 16'h0000, 1'b1},
            '{1'b1, 16'h01FE, 16'h7E7E, 2'b11, 16'h0000, 1'b0},
            '{1'b0, 16'h01FE, 16'h0000, 2'b00, 16'h7E7E, 1'b0}
        };
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

        // Reset state
        repeat (3) step();
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.done",  32'(bus.init_done), 32'd0);
        chk_rsp("rst", 1'b0, 16'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init0");

        // Table: requests issued back-to-back, one per cycle
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            step();
            chk_rsp($sformatf("vec%0d", i), 1'b1, vecs[i].exp_rdata, vecs[i].exp_err);
`ifdef DMEM_PARITY_EN
            chk($sformatf("vec%0d.perr", i), 32'(bus.rsp_perr), 32'd0);
`endif
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        step();
        chk_rsp("idle", 1'b0, 16'h0, 1'b0);

        // Store then load of the same word on consecutive edges
        drive(1'b1, 1'b1, 16'h0004, 16'hA5A5, 2'b11);
        step();
        chk_rsp("b2b.st", 1'b1, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00);
        step();
        chk_rsp("b2b.ld", 1'b1, 16'hA5A5, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        step();
        chk_rsp("b2b.idle", 1'b0, 16'h0, 1'b0);

        // Reset after stores, then a second reset at sweep counter 100
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst1.done",  32'(bus.init_done), 32'd0);
        chk("rst1.ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) step();
        chk("mid.done", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2.done", 32'(bus.init_done), 32'd0);
        chk_rsp("rst2", 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init2");
        load("clr.0010", 16'h0010, 16'h0000);
        load("clr.0004", 16'h0004, 16'h0000);
        load("clr.0002", 16'h0002, 16'h0000);
        load("clr.01FE", 16'h01FE, 16'h0000);

`ifdef DMEM_PARITY_EN
        // Corrupt one stored parity bit; data still returned with rsp_perr set
        store(16'h0010, 16'h1234, 2'b11);
        load("par.clean", 16'h0010, 16'h1234);
        chk("par.clean.perr", 32'(bus.rsp_perr), 32'd0);
        u_dut.u_ram.mem[8][1][8] = ~u_dut.u_ram.mem[8][1][8];
        load("par.flip", 16'h0010, 16'h1234);
        chk("par.flip.perr", 32'(bus.rsp_perr), 32'd1);
`else
        store(16'h0010, 16'h1234, 2'b11);
        load("st.final", 16'h0010, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
